// File: rtl/wave_display_pkg.sv
// wave_display_pkg: shared window bounds, colours and pipeline types for the waveform display
package wave_display_pkg;
  localparam logic [1:0] WIN_X_SEL = 2'b01;
  localparam logic [7:0] COL_LIT = 8'hFF;
  localparam logic [7:0] COL_GRID = 8'h40;
  localparam logic [7:0] COL_OFF = 8'h00;
  localparam int LATENCY = 2;
  typedef struct packed {
    logic valid;
    logic win;
    logic [7:0] row;
    logic [7:0] sample;
  } s1_t;
  function automatic logic in_window(input logic [1:0] x_hi, input logic y_hi);
    return x_hi == WIN_X_SEL && !y_hi;
  endfunction
endpackage

// File: rtl/wave_line_hit.sv
// wave_line_hit: true when row lies within the inclusive span between two plotted rows
module wave_line_hit (
  input  logic [7:0] row_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       hit_o
);
  logic [7:0] lo, hi;
  assign lo = (a_i < b_i) ? a_i : b_i;
  assign hi = (a_i < b_i) ? b_i : a_i;
  assign hit_o = row_i >= lo && row_i <= hi;
endmodule

// File: rtl/wave_display.sv
// wave_display: plots 256 captured samples as a connected line; WAVE_DISPLAY_GRID_EN adds a dim grid
module wave_display
  import wave_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic        read_index,
  output logic [8:0]  read_address,
  input  logic [7:0]  read_value,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        wave_display_idle
);
  logic latched_q, idx, frame_start, hit_raw, hit, valid_pixel_q, idle_q, unused_bits;
  logic [7:0] prev_v_q, last_v_q, last_sample_q, v, pv, col_q, col_d;
  s1_t s1_q, s1_d;
  assign unused_bits = ^{x[0], y[0]};
  assign frame_start = valid && x == 11'd0 && y == 10'd0;
  // the frame-start pixel already reads from the newly frozen half
  assign idx = frame_start ? read_index : latched_q;
  assign read_address = {idx, x[8:1]};
  assign s1_d = '{valid: valid, win: in_window(x[10:9], y[9]), row: y[8:1], sample: x[8:1]};
  assign v = 8'd255 - read_value;
  // first pixel of a new sample takes the previous sample's v; sample 0 never joins sample 255
  assign pv = s1_q.sample == 8'd0 ? v : (s1_q.sample != last_sample_q) ? last_v_q : prev_v_q;
  wave_line_hit u_hit (.row_i(s1_q.row), .a_i(pv), .b_i(v), .hit_o(hit_raw));
  assign hit = s1_q.win && hit_raw;
`ifdef WAVE_DISPLAY_GRID_EN
  logic grid_q;
  always_ff @(posedge clk)
    if (reset) grid_q <= 1'b0;
    else grid_q <= in_window(x[10:9], y[9]) && (x[5:0] == 6'd0 || y[4:0] == 5'd0);
  assign col_d = !s1_q.valid ? COL_OFF : hit ? COL_LIT : grid_q ? COL_GRID : COL_OFF;
`else
  assign col_d = (s1_q.valid && hit) ? COL_LIT : COL_OFF;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      latched_q <= 1'b0;
      s1_q <= '0;
      prev_v_q <= '0;
      last_v_q <= '0;
      last_sample_q <= '0;
      valid_pixel_q <= 1'b0;
      col_q <= COL_OFF;
      idle_q <= 1'b0;
    end else begin
      latched_q <= idx;
      s1_q <= s1_d;
      if (s1_q.valid && s1_q.win) begin
        last_sample_q <= s1_q.sample;
        last_v_q <= v;
        prev_v_q <= pv;
      end
      valid_pixel_q <= s1_q.valid;
      col_q <= col_d;
      idle_q <= valid && y[9];
    end
  end
  assign valid_pixel = valid_pixel_q;
  assign r = col_q;
  assign g = col_q;
  assign b = col_q;
  assign wave_display_idle = idle_q;
endmodule
